// File: rtl/fpadd_pkg.sv
// Shared types for the FP adder mantissa stage: width defaults, the result
// payload carried through the skid buffer, and the buffer occupancy encoding.
package fpadd_pkg;

  localparam int MANT_W_DEF = 32;  // {hidden, 23 fraction, 8 guard}
  localparam int EXP_W_DEF  = 8;

  // One finished add/sub result as it travels toward the normalizer.
  typedef struct packed {
    logic                  sign;
    logic [MANT_W_DEF:0]   mantissa;  // bit MANT_W is the carry
    logic [EXP_W_DEF-1:0]  exponent;
    logic                  sticky;
    logic                  bypass;
    logic                  zero;
  } addPayload_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/mantissa_add_skid.sv
// Two-entry skid buffer. The head register drives the consumer directly and
// the ready toward the producer is registered, so no combinational path
// exists from pop_ready to push_ready.
import fpadd_pkg::*;

module mantissa_add_skid #(
  parameter type payload_t = addPayload_t
) (
  input  logic     clk,
  input  logic     resetN,
  input  logic     push_valid,
  output logic     push_ready,
  input  payload_t push_data,
  output logic     pop_valid,
  input  logic     pop_ready,
  output payload_t head
);

  occ_t     occ;
  payload_t skid;
  logic     push;
  logic     pop;

  assign push = push_valid && push_ready;
  assign pop  = pop_valid && pop_ready;

  // Occupancy FSM; head/skid storage and both handshake flags are registered.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      occ        <= OCC_EMPTY;
      head       <= '0;
      skid       <= '0;
      pop_valid  <= 1'b0;
      push_ready <= 1'b1;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (push) begin
            head      <= push_data;
            occ       <= OCC_ONE;
            pop_valid <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head <= push_data;
          end else if (push) begin
            skid       <= push_data;
            occ        <= OCC_TWO;
            push_ready <= 1'b0;
          end else if (pop) begin
            occ       <= OCC_EMPTY;
            pop_valid <= 1'b0;
          end
        end
        OCC_TWO: begin
          // push_ready is low here, so only a pop can happen.
          if (pop) begin
            head       <= skid;
            occ        <= OCC_ONE;
            push_ready <= 1'b1;
          end
        end
        default: begin
          occ        <= OCC_EMPTY;
          pop_valid  <= 1'b0;
          push_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mantissa_add_stage.sv
// Mantissa add/subtract stage of the FP adder. Computes the signed-magnitude
// sum of two aligned mantissas and hands the result to the normalizer through
// a two-entry skid buffer (one cycle latency when empty).
// Optional macro MANTADD_STATS_EN adds saturating add/sub/stall counters.
import fpadd_pkg::*;

module mantissa_add_stage #(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              inValid,
  output logic              inReady,
  input  logic              signA,
  input  logic              signB,
  input  logic [MANT_W-1:0] alignedMantissaA,
  input  logic [MANT_W-1:0] alignedMantissaB,
  input  logic [EXP_W-1:0]  exponentIn,
  input  logic              stickyIn,
  input  logic              shiftOverflow,
  input  logic              bypassALU,
  output logic              outValid,
  input  logic              outReady,
  output logic [MANT_W:0]   sumMantissa,
  output logic              signOut,
  output logic [EXP_W-1:0]  exponentOut,
  output logic              stickyOut,
  output logic              bypassOut,
`ifdef MANTADD_STATS_EN
  output logic [15:0]       addCount,
  output logic [15:0]       subCount,
  output logic [15:0]       stallCount,
`endif
  output logic              zeroResult
);

  addPayload_t result;
  addPayload_t head;
  logic        eff_sub;
  logic        a_ge_b;

  assign eff_sub = signA ^ signB;
  assign a_ge_b  = alignedMantissaA >= alignedMantissaB;

  // Signed-magnitude add: same signs add, different signs subtract the
  // smaller magnitude from the larger and take the larger operand's sign.
  always_comb begin
    result          = '0;
    result.exponent = exponentIn;
    result.sticky   = stickyIn | shiftOverflow;
    result.bypass   = bypassALU;
    result.sign     = signA;
    if (bypassALU) begin
      result.mantissa = '0;
    end else if (!eff_sub) begin
      result.mantissa = {1'b0, alignedMantissaA} + {1'b0, alignedMantissaB};
    end else if (alignedMantissaA == alignedMantissaB) begin
      // Exact cancellation always yields +0.
      result.mantissa = '0;
      result.sign     = 1'b0;
    end else if (a_ge_b) begin
      result.mantissa = {1'b0, alignedMantissaA - alignedMantissaB};
      result.sign     = signA;
    end else begin
      result.mantissa = {1'b0, alignedMantissaB - alignedMantissaA};
      result.sign     = signB;
    end
    result.zero = !bypassALU && (result.mantissa == '0);
  end

  mantissa_add_skid #(.payload_t(addPayload_t)) u_skid (
    .clk        (clk),
    .resetN     (resetN),
    .push_valid (inValid),
    .push_ready (inReady),
    .push_data  (result),
    .pop_valid  (outValid),
    .pop_ready  (outReady),
    .head       (head)
  );

  assign sumMantissa = head.mantissa;
  assign signOut     = head.sign;
  assign exponentOut = head.exponent;
  assign stickyOut   = head.sticky;
  assign bypassOut   = head.bypass;
  assign zeroResult  = head.zero;

`ifdef MANTADD_STATS_EN
  logic accept;
  assign accept = inValid && inReady;

  // Saturating event counters: accepted adds, accepted subtracts, and
  // cycles the normalizer held a valid result back.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      addCount   <= '0;
      subCount   <= '0;
      stallCount <= '0;
    end else begin
      if (accept && !bypassALU && !eff_sub && addCount != 16'hFFFF)
        addCount <= addCount + 16'd1;
      if (accept && !bypassALU && eff_sub && subCount != 16'hFFFF)
        subCount <= subCount + 16'd1;
      if (outValid && !outReady && stallCount != 16'hFFFF)
        stallCount <= stallCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mantissa_add_stage.sv
// Directed bench for mantissa_add_stage: a vector table applied one set at a
// time, then hand-written skid-buffer and reset-mid-transfer sequences.
module tb_mantissa_add_stage;

  localparam int MW = 32;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic          signA = 1'b0, signB = 1'b0;
  logic [MW-1:0] mantA = '0, mantB = '0;
  logic [EW-1:0] expIn = '0;
  logic          stickyIn = 1'b0, shiftOverflow = 1'b0, bypassALU = 1'b0;
  logic          outValid;
  logic          outReady = 1'b0;
  logic [MW:0]   sumMantissa;
  logic          signOut;
  logic [EW-1:0] exponentOut;
  logic          stickyOut, bypassOut, zeroResult;
`ifdef MANTADD_STATS_EN
  logic [15:0]   addCount, subCount, stallCount;
`endif

  mantissa_add_stage #(.MANT_W(MW), .EXP_W(EW)) dut (
    .clk              (clk),
    .resetN           (resetN),
    .inValid          (inValid),
    .inReady          (inReady),
    .signA            (signA),
    .signB            (signB),
    .alignedMantissaA (mantA),
    .alignedMantissaB (mantB),
    .exponentIn       (expIn),
    .stickyIn         (stickyIn),
    .shiftOverflow    (shiftOverflow),
    .bypassALU        (bypassALU),
    .outValid         (outValid),
    .outReady         (outReady),
    .sumMantissa      (sumMantissa),
    .signOut          (signOut),
    .exponentOut      (exponentOut),
    .stickyOut        (stickyOut),
    .bypassOut        (bypassOut),
`ifdef MANTADD_STATS_EN
    .addCount         (addCount),
    .subCount         (subCount),
    .stallCount       (stallCount),
`endif
    .zeroResult       (zeroResult)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sa, sb;
    logic [MW-1:0] a, b;
    logic [EW-1:0] e;
    logic          st, ov, by;
    logic [MW:0]   xsum;
    logic          xsign, xzero, xsticky, xbyp;
  } vec_t;

  vec_t vt [9];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    signA = v.sa; signB = v.sb; mantA = v.a; mantB = v.b; expIn = v.e;
    stickyIn = v.st; shiftOverflow = v.ov; bypassALU = v.by;
  endtask

  task automatic check_out(input string tag, input vec_t v);
    chk({tag, "_valid"},  64'(outValid),    64'd1);
    chk({tag, "_sum"},    64'(sumMantissa), 64'(v.xsum));
    chk({tag, "_sign"},   64'(signOut),     64'(v.xsign));
    chk({tag, "_zero"},   64'(zeroResult),  64'(v.xzero));
    chk({tag, "_sticky"}, 64'(stickyOut),   64'(v.xsticky));
    chk({tag, "_bypass"}, 64'(bypassOut),   64'(v.xbyp));
    chk({tag, "_exp"},    64'(exponentOut), 64'(v.e));
  endtask

  initial begin
    //        sa    sb    a             b             e      st    ov    by    xsum            xsign xzero xst  xby
    vt[0] = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, 8'h7F, 1'b0, 1'b0, 1'b0, 33'h100000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 32'hC0000000, 32'hE0000000, 8'h80, 1'b0, 1'b0, 1'b0, 33'h020000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 32'h90000000, 32'h90000000, 8'h10, 1'b0, 1'b0, 1'b0, 33'h0,         1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b0, 32'h00000005, 32'h00000003, 8'h22, 1'b0, 1'b1, 1'b1, 33'h0,         1'b1, 1'b0, 1'b1, 1'b1};
    vt[4] = '{1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFF, 8'hFE, 1'b0, 1'b0, 1'b0, 33'h100000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b0, 32'h12345678, 32'h02345678, 8'h01, 1'b0, 1'b0, 1'b0, 33'h010000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 8'h00, 1'b0, 1'b0, 1'b0, 33'h0,         1'b0, 1'b1, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b0, 32'h00000001, 32'h00000002, 8'h55, 1'b1, 1'b0, 1'b0, 33'h3,         1'b0, 1'b0, 1'b1, 1'b0};
    vt[8] = '{1'b0, 1'b1, 32'h00000010, 32'h00000011, 8'hAA, 1'b1, 1'b1, 1'b0, 33'h1,         1'b1, 1'b0, 1'b1, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_outValid", 64'(outValid),    64'd0);
    chk("rst_inReady",  64'(inReady),     64'd1);
    chk("rst_sum",      64'(sumMantissa), 64'd0);
    chk("rst_flags",    64'({signOut, stickyOut, bypassOut, zeroResult}), 64'd0);
`ifdef MANTADD_STATS_EN
    chk("rst_counters", 64'({addCount, subCount, stallCount}), 64'd0);
`endif
    resetN   = 1'b1;
    outReady = 1'b1;

    // Table: one set at a time, result expected one cycle after acceptance.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vt[i]);
      inValid = 1'b1;
      @(negedge clk);
      check_out($sformatf("v%0d", i), vt[i]);
      inValid = 1'b0;
    end
    @(negedge clk);
    chk("drain_empty", 64'(outValid), 64'd0);

    // Back-pressure: two sets accepted, third refused, head held stable.
    outReady = 1'b0;
    drive(vt[0]); inValid = 1'b1;
    @(negedge clk);
    check_out("sk_x1", vt[0]);
    chk("sk_ready1", 64'(inReady), 64'd1);
    drive(vt[1]);
    @(negedge clk);
    check_out("sk_x2", vt[0]);
    chk("sk_full", 64'(inReady), 64'd0);
    drive(vt[2]);
    @(negedge clk);
    check_out("sk_x3", vt[0]);
    chk("sk_still_full", 64'(inReady), 64'd0);
    inValid  = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    check_out("sk_y", vt[1]);
    chk("sk_ready_back", 64'(inReady), 64'd1);
    @(negedge clk);
    chk("sk_empty", 64'(outValid), 64'd0);

    // Reset with two entries buffered.
    outReady = 1'b0;
    drive(vt[3]); inValid = 1'b1;
    @(negedge clk);
    drive(vt[4]);
    @(negedge clk);
    inValid = 1'b0;
    chk("pre_rst_full", 64'(inReady), 64'd0);
    resetN = 1'b0;
    #1;
    chk("mid_rst_outValid", 64'(outValid),    64'd0);
    chk("mid_rst_inReady",  64'(inReady),     64'd1);
    chk("mid_rst_sum",      64'(sumMantissa), 64'd0);
    chk("mid_rst_flags",    64'({signOut, stickyOut, bypassOut, zeroResult, exponentOut}), 64'd0);
`ifdef MANTADD_STATS_EN
    chk("mid_rst_counters", 64'({addCount, subCount, stallCount}), 64'd0);
`endif
    @(negedge clk);
    resetN   = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    drive(vt[5]); inValid = 1'b1;
    @(negedge clk);
    check_out("post_rst", vt[5]);
    inValid = 1'b0;
`ifdef MANTADD_STATS_EN
    chk("post_rst_subCount", 64'(subCount), 64'd1);
    chk("post_rst_addCount", 64'(addCount), 64'd0);
`endif
    @(negedge clk);
    chk("post_rst_empty", 64'(outValid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mantissa_add_stage.md
MANTISSA_ADD_STAGE -- requirements
Module: mantissa_add_stage

Interface
REQ-001 SHALL have parameter MANT_W, default 32, meaning aligned-mantissa width ({hidden, 23 fraction, 8 guard}).
REQ-002 SHALL have parameter EXP_W, default 8, meaning exponent width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports clk and resetN come first.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 resetN  input  1  asynchronous active-low reset.
REQ-006 inValid  input  1  upstream (alignment) holds a valid operand set.
REQ-007 inReady  output  1  stage accepts the operand set this cycle.
REQ-008 signA, signB  input  1 each  operand signs.
REQ-009 alignedMantissaA, alignedMantissaB  input  MANT_W each  aligned mantissas.
REQ-010 exponentIn  input  EXP_W  common exponent.
REQ-011 stickyIn, shiftOverflow, bypassALU  input  1 each  alignment side information.
REQ-012 outValid  output  1  result available; outReady  input  1  downstream (normalizer) accepts it.
REQ-013 sumMantissa  output  MANT_W+1  raw sum/difference, bit MANT_W is the carry.
REQ-014 signOut  output  1; exponentOut  output  EXP_W; stickyOut  output  1; bypassOut  output  1; zeroResult  output  1.

Function
REQ-015 Transfer in SHALL occur on inValid && inReady; transfer out on outValid && outReady.
REQ-016 Latency SHALL be exactly 1 cycle: an accepted set appears on outputs the next cycle when the buffer is empty.
REQ-017 Storage SHALL be a 2-entry skid buffer; inReady SHALL be registered and equal !full (never combinationally dependent on outReady).
REQ-018 Occupancy transitions: EMPTY->ONE on push; ONE->TWO on push without pop; TWO->ONE on pop; ONE->EMPTY on pop without push; simultaneous push and pop SHALL keep occupancy.
REQ-019 Outputs SHALL be held stable while outValid && !outReady.
REQ-020 Equal signs: sumMantissa = A + B zero-extended to MANT_W+1, signOut = signA.
REQ-021 Unequal signs: sumMantissa = larger − smaller (unsigned compare of aligned mantissas), signOut = sign of larger; carry bit 0.
REQ-022 Unequal signs with equal magnitudes: sumMantissa = 0, signOut = 0, zeroResult = 1.
REQ-023 zeroResult SHALL be 1 whenever sumMantissa is 0 and bypassALU is 0.
REQ-024 stickyOut = stickyIn | shiftOverflow; exponentOut = exponentIn unchanged.
REQ-025 bypassALU = 1: sumMantissa = 0, zeroResult = 0, bypassOut = 1, other fields passed through.
REQ-026 Push into a full buffer SHALL not occur (inReady = 0); inValid while full SHALL be ignored without data loss.

Reset
REQ-027 On resetN low, asynchronously: occupancy EMPTY, outValid = 0, inReady = 1, sumMantissa/exponentOut = 0, all 1-bit outputs 0.
REQ-028 Reset mid-transfer SHALL discard all buffered entries; first result after release is the first set accepted after release.

Configuration
REQ-029 Macro MANTADD_STATS_EN defined: 16-bit saturating counters addCount, subCount and stallCount (cycles with outValid && !outReady) SHALL exist as outputs, reset to 0.
REQ-030 Macro undefined: counters and their ports SHALL be absent; datapath behaviour identical.

Structure
REQ-031 Package fpadd_pkg SHALL hold MANT_W/EXP_W defaults and typedef addPayload_t (signs, mantissas, exponent, sticky, bypass, zero flags).
REQ-032 Buffer SHALL be a sub-module mantissa_add_skid, parameterized on addPayload_t; arithmetic stays in mantissa_add_stage.

Verification
REQ-033 A=0x80000000, B=0x80000000, signs 0/0 -> next cycle sumMantissa=0x100000000, signOut=0, outValid=1.
REQ-034 A=0xC0000000 sign 0, B=0xE0000000 sign 1 -> sumMantissa=0x020000000, signOut=1.
REQ-035 A=B=0x90000000, signs 0/1 -> sumMantissa=0, signOut=0, zeroResult=1.
REQ-036 outReady=0, three back-to-back inValid -> two accepted, inReady=0 on third, outputs stable; outReady=1 -> both drain in order.
REQ-037 bypassALU=1, stickyIn=0, shiftOverflow=1 -> sumMantissa=0, bypassOut=1, stickyOut=1.
REQ-038 resetN asserted with two entries buffered -> outValid=0, inReady=1 immediately; with MANTADD_STATS_EN, counters read 0.
